sv_frame_blend: RTL and testbench

//  Pixel post-processor between the SuperVision core video output and video_mixer.
//  - Maps the 2-bit pixel stream through a 4-entry RGB palette, default or user-loaded.
//  - Optionally averages each pixel with the same pixel of the previous frame (flickerblend).
//  - Re-times sync/blank to stay aligned with the RGB output.

---
 rtl/sv_frame_blend.sv | 203 ++++++++++++++++++++
 tb/tb_sv_frame_blend.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_frame_blend.sv
// sv_frame_blend: pixel post-processor between the SuperVision core and video_mixer.
// Maps the 2-bit pixel stream through a 4-entry RGB palette, optionally averages
// each pixel with the same pixel of the previous frame, and re-times sync/blank
// so they stay aligned with the colour output (2 ce_pix strobes of latency).
//
// Build option: define USER_PALETTE_EN to build the 12-byte user palette and its
// write port; otherwise DEF_PAL is always used and pal_* inputs are ignored.
//
// Ports:
//   clk_sys, reset        clock, synchronous active-high reset
//   ce_pix                pixel clock enable; both pipeline stages advance on it
//   pixel, hsync, vsync,
//   hblank, vblank        core video stream
//   blend_en              1 = average with previous frame
//   pal_sel               1 = user palette, 0 = DEF_PAL
//   pal_wr/addr/din       user palette byte write (byte n -> entry n/3, R/G/B = n%3)
//   r, g, b               registered colour output
//   hs_out, vs_out,
//   hbl_out, vbl_out      sync/blank delayed to match r/g/b
module sv_frame_blend #(
  parameter int unsigned ADDR_W  = 15,
  parameter logic [95:0] DEF_PAL = 96'h87BA6B_6BA378_386B82_384052
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [1:0] pixel,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       blend_en,
  input  logic       pal_sel,
  input  logic       pal_wr,
  input  logic [3:0] pal_addr,
  input  logic [7:0] pal_din,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hs_out,
  output logic       vs_out,
  output logic       hbl_out,
  output logic       vbl_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Previous-frame buffer: one 2-bit palette index per visible pixel
  logic [1:0] buf_mem [DEPTH];

  logic [ADDR_W-1:0] addr_q, addr_d;     // address of the pixel entering S0
  logic [ADDR_W-1:0] waddr_q, waddr_d;   // address of the pixel held in S0
  logic [1:0]        pix0_q, pix0_d;
  logic              hs0_q, hs0_d, vs0_q, vs0_d, hb0_q, hb0_d, vb0_q, vb0_d;
  logic [1:0]        prev_pix_q, prev_pix_d;
  logic              prev_valid_q, prev_valid_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              hs_q, hs_d, vs_q, vs_d, hbl_q, hbl_d, vbl_q, vbl_d;

  logic        active_in, active0, buf_we;
  logic [95:0] act_pal;
  logic [23:0] cur_rgb, prv_rgb, blend_rgb;

  function automatic logic [23:0] pal_entry(input logic [95:0] pal, input logic [1:0] idx);
    case (idx)
      2'd0:    pal_entry = pal[95:72];
      2'd1:    pal_entry = pal[71:48];
      2'd2:    pal_entry = pal[47:24];
      default: pal_entry = pal[23:0];
    endcase
  endfunction

  // 9-bit sum, halved back to 8 bits
  function automatic logic [7:0] avg8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s    = {1'b0, x} + {1'b0, y};
    avg8 = s[8:1];
  endfunction

`ifdef USER_PALETTE_EN
  logic [95:0] upal_q, upal_d;

  // User palette byte writes; a lookup in the same clock still sees the old byte
  always_comb begin
    upal_d = upal_q;
    for (int i = 0; i < 12; i++) begin
      if (pal_wr && (pal_addr == 4'(i))) upal_d[95 - 8*i -: 8] = pal_din;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) upal_q <= DEF_PAL;
    else       upal_q <= upal_d;
  end

  assign act_pal = pal_sel ? upal_q : DEF_PAL;
`else
  logic pal_unused;
  assign pal_unused = ^{pal_sel, pal_wr, pal_addr, pal_din};
  assign act_pal    = DEF_PAL;
`endif

  assign active_in = ~hblank & ~vblank;
  assign active0   = ~hb0_q & ~vb0_q;
  assign buf_we    = ce_pix & active0 & ~reset;

  // Colour lookup and blend for the pixel held in S0 (produces the S1 result)
  always_comb begin
    cur_rgb   = pal_entry(act_pal, pix0_q);
    prv_rgb   = pal_entry(act_pal, prev_pix_q);
    blend_rgb = {avg8(cur_rgb[23:16], prv_rgb[23:16]),
                 avg8(cur_rgb[15:8],  prv_rgb[15:8]),
                 avg8(cur_rgb[7:0],   prv_rgb[7:0])};
  end

  // Next-state for both pipeline stages, address counter and prev_valid
  always_comb begin
    addr_d       = addr_q;
    waddr_d      = waddr_q;
    pix0_d       = pix0_q;
    hs0_d        = hs0_q;
    vs0_d        = vs0_q;
    hb0_d        = hb0_q;
    vb0_d        = vb0_q;
    prev_pix_d   = prev_pix_q;
    prev_valid_d = prev_valid_q;
    rgb_d        = rgb_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    hbl_d        = hbl_q;
    vbl_d        = vbl_q;
    if (ce_pix) begin
      // S0: capture input, start buffer read at the current address
      pix0_d     = pixel;
      hs0_d      = hsync;
      vs0_d      = vsync;
      hb0_d      = hblank;
      vb0_d      = vblank;
      waddr_d    = addr_q;
      prev_pix_d = buf_mem[addr_q];
      if (vsync)          addr_d = '0;
      else if (active_in) addr_d = addr_q + ADDR_W'(1);
      // A falling vsync marks a complete frame in the buffer
      if (vs0_q && !vsync) prev_valid_d = 1'b1;
      // S1: drive outputs from the S0 pixel
      if (!active0)                     rgb_d = '0;
      else if (blend_en && prev_valid_q) rgb_d = blend_rgb;
      else                              rgb_d = cur_rgb;
      hs_d  = hs0_q;
      vs_d  = vs0_q;
      hbl_d = hb0_q;
      vbl_d = vb0_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_q       <= '0;
      waddr_q      <= '0;
      pix0_q       <= '0;
      hs0_q        <= 1'b0;
      vs0_q        <= 1'b0;
      hb0_q        <= 1'b1;
      vb0_q        <= 1'b1;
      prev_pix_q   <= '0;
      prev_valid_q <= 1'b0;
      rgb_q        <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      hbl_q        <= 1'b1;
      vbl_q        <= 1'b1;
    end else begin
      addr_q       <= addr_d;
      waddr_q      <= waddr_d;
      pix0_q       <= pix0_d;
      hs0_q        <= hs0_d;
      vs0_q        <= vs0_d;
      hb0_q        <= hb0_d;
      vb0_q        <= vb0_d;
      prev_pix_q   <= prev_pix_d;
      prev_valid_q <= prev_valid_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      hbl_q        <= hbl_d;
      vbl_q        <= vbl_d;
    end
  end

  // Buffer contents survive reset; only active S0 pixels are stored
  always_ff @(posedge clk_sys) begin
    if (buf_we) buf_mem[waddr_q] <= pix0_q;
  end

  assign r       = rgb_q[23:16];
  assign g       = rgb_q[15:8];
  assign b       = rgb_q[7:0];
  assign hs_out  = hs_q;
  assign vs_out  = vs_q;
  assign hbl_out = hbl_q;
  assign vbl_out = vbl_q;

endmodule

// File: tb/tb_sv_frame_blend.sv
// Testbench for sv_frame_blend: random and directed frames are checked through a
// scoreboard against a frame-level reference model (palette table, previous-frame
// array, address counter with wrap at 16 entries).
module tb_sv_frame_blend;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, ce_pix, hsync, vsync, hblank, vblank, blend_en, pal_sel, pal_wr;
  logic [1:0] pixel;
  logic [3:0] pal_addr;
  logic [7:0] pal_din;
  logic [7:0] r, g, b;
  logic       hs_out, vs_out, hbl_out, vbl_out;

  sv_frame_blend #(.ADDR_W(AW)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .ce_pix  (ce_pix),
    .pixel   (pixel),
    .hsync   (hsync),
    .vsync   (vsync),
    .hblank  (hblank),
    .vblank  (vblank),
    .blend_en(blend_en),
    .pal_sel (pal_sel),
    .pal_wr  (pal_wr),
    .pal_addr(pal_addr),
    .pal_din (pal_din),
    .r       (r),
    .g       (g),
    .b       (b),
    .hs_out  (hs_out),
    .vs_out  (vs_out),
    .hbl_out (hbl_out),
    .vbl_out (vbl_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  pix;
    logic        hs, vs, hb, vb;
    logic [1:0]  prev;
    int unsigned waddr;
  } stage_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic [3:0]  sy;   // {hs, vs, hblank, vblank}
  } exp_t;

  // Reference model state
  logic [1:0]  mem_m [DEPTH];
  int unsigned addr_m;
  bit          pv_m;
  logic [7:0]  upal_m [12];
  logic [7:0]  def_b [12];
  stage_t      st;
  exp_t        q[$];

  int n_chk = 0;
  int n_fail = 0;
  bit rnd_pal = 1'b0;

  task automatic check(input string nm, input logic [27:0] act, input logic [27:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, expv);
    end
  endtask

  function automatic logic [23:0] pal_m(input logic [1:0] idx);
    logic [23:0] e;
    bit use_user;
`ifdef USER_PALETTE_EN
    use_user = pal_sel;
`else
    use_user = 1'b0;
`endif
    for (int c = 0; c < 3; c++)
      e[23 - 8*c -: 8] = use_user ? upal_m[3*idx + c] : def_b[3*idx + c];
    return e;
  endfunction

  task automatic model_reset();
    st     = '{pix: 2'd0, hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1, prev: 2'd0, waddr: 0};
    addr_m = 0;
    pv_m   = 1'b0;
    for (int i = 0; i < 12; i++) upal_m[i] = def_b[i];
  endtask

  // One ce_pix strobe: predict the output it produces, then advance the model
  task automatic model_strobe();
    exp_t        e;
    logic [23:0] cur, prv;
    logic [1:0]  rd;
    cur = pal_m(st.pix);
    prv = pal_m(st.prev);
    if (st.hb || st.vb) e.rgb = 24'h0;
    else if (blend_en && pv_m) begin
      for (int c = 0; c < 3; c++)
        e.rgb[23 - 8*c -: 8] = 8'((int'(cur[23 - 8*c -: 8]) + int'(prv[23 - 8*c -: 8])) / 2);
    end else e.rgb = cur;
    e.sy = {st.hs, st.vs, st.hb, st.vb};
    q.push_back(e);
    rd = mem_m[addr_m];
    if (!st.hb && !st.vb) mem_m[st.waddr] = st.pix;
    if (st.vs && !vsync) pv_m = 1'b1;
    st = '{pix: pixel, hs: hsync, vs: vsync, hb: hblank, vb: vblank, prev: rd, waddr: addr_m};
    if (vsync) addr_m = 0;
    else if (!hblank && !vblank) addr_m = (addr_m + 1) % DEPTH;
  endtask

  task automatic model_palwr();
`ifdef USER_PALETTE_EN
    if (pal_wr && pal_addr < 4'd12) upal_m[pal_addr] = pal_din;
`endif
  endtask

  task automatic step(input bit ce, input bit rst);
    ce_pix = ce;
    reset  = rst;
    if (rst) model_reset();
    else begin
      if (ce) model_strobe();
      model_palwr();
    end
    @(negedge clk);
    pal_wr = 1'b0;
  endtask

  task automatic rand_palwr();
    if ($urandom_range(3) == 0) begin
      pal_wr   = 1'b1;
      pal_addr = 4'($urandom_range(15));
      pal_din  = 8'($urandom);
    end
  endtask

  task automatic idle();
    pixel  = 2'($urandom);
    hsync  = 1'($urandom);
    vsync  = 1'($urandom);
    hblank = 1'($urandom);
    vblank = 1'($urandom);
    if (rnd_pal) rand_palwr();
    step(1'b0, 1'b0);
  endtask

  task automatic send(input logic [1:0] p, input bit hs, input bit vs, input bit hb, input bit vb);
    pixel  = p;
    hsync  = hs;
    vsync  = vs;
    hblank = hb;
    vblank = vb;
    if (rnd_pal) rand_palwr();
    step(1'b1, 1'b0);
    repeat ($urandom_range(2)) idle();
  endtask

  task automatic wr_byte(input logic [3:0] a, input logic [7:0] d);
    pal_addr = a;
    pal_din  = d;
    pal_wr   = 1'b1;
    step(1'b0, 1'b0);
  endtask

  // 3 lines of 6 active + 2 hblank pixels, then a vblank with a 1-strobe vsync.
  // mode < 0 gives random pixels. Active pixel chk_pos is checked against chk_val.
  task automatic frame(input int mode, input int chk_pos, input logic [23:0] chk_val);
    int         n = 0;
    bit         pend = 1'b0;
    logic [1:0] p;
    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < 8; x++) begin
        p = (mode < 0) ? 2'($urandom) : 2'(mode);
        send(p, x == 7, 1'b0, x >= 6, 1'b0);
        if (pend) begin
          check("directed_rgb", {4'h0, r, g, b}, {4'h0, chk_val});
          pend = 1'b0;
        end
        if (x < 6) begin
          if (n == chk_pos) pend = 1'b1;
          n++;
        end
      end
    end
    send(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    send(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  // Monitor: pops the expected output after every strobe, checks reset values
  // and checks that outputs hold when ce_pix is low
  initial begin
    exp_t last, e;
    bit   rst_s, ce_s;
    last = '{rgb: 24'h0, sy: 4'b0011};
    forever begin
      @(posedge clk);
      rst_s = reset;
      ce_s  = ce_pix;
      @(negedge clk);
      if (rst_s) begin
        e = '{rgb: 24'h0, sy: 4'b0011};
        check("reset_val", {r, g, b, hs_out, vs_out, hbl_out, vbl_out}, e);
        last = e;
      end else if (ce_s) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_empty at %0t: got strobe, expected queued entry", $time);
        end else begin
          e = q.pop_front();
          check("strobe_out", {r, g, b, hs_out, vs_out, hbl_out, vbl_out}, e);
          last = e;
        end
      end else begin
        check("hold_out", {r, g, b, hs_out, vs_out, hbl_out, vbl_out}, last);
      end
    end
  end

  initial begin
    def_b = '{8'h87, 8'hBA, 8'h6B, 8'h6B, 8'hA3, 8'h78,
              8'h38, 8'h6B, 8'h82, 8'h38, 8'h40, 8'h52};
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 2'd0;
    reset = 1'b1; ce_pix = 1'b0; pixel = 2'd0;
    hsync = 1'b0; vsync = 1'b0; hblank = 1'b1; vblank = 1'b1;
    blend_en = 1'b0; pal_sel = 1'b0; pal_wr = 1'b0; pal_addr = 4'd0; pal_din = 8'd0;

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (5) idle();

    // Plain palette, index 2
    blend_en = 1'b0;
    pal_sel  = 1'b0;
    frame(2, 3, 24'h386B82);

    // Blend: first frame unblended, second averages idx3 with idx0
    step(1'b0, 1'b1);
    blend_en = 1'b1;
    frame(0, 4, 24'h87BA6B);
    frame(3, 4, 24'h5F7D5E);

    // User palette bytes 0..2, plus an out-of-range write
    blend_en = 1'b0;
    wr_byte(4'd0, 8'hFF);
    wr_byte(4'd1, 8'h00);
    wr_byte(4'd2, 8'h80);
    wr_byte(4'd13, 8'h55);
    pal_sel = 1'b1;
`ifdef USER_PALETTE_EN
    frame(0, 2, 24'hFF0080);
`else
    frame(0, 2, 24'h87BA6B);
`endif

    // Random frames with random palette writes
    rnd_pal = 1'b1;
    for (int f = 0; f < 6; f++) begin
      blend_en = 1'($urandom);
      pal_sel  = 1'($urandom);
      frame(-1, -1, 24'h0);
    end

    // Reset mid-line, then continue blending
    blend_en = 1'b1;
    for (int i = 0; i < 4; i++) send(2'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      pal_sel = 1'($urandom);
      frame(-1, -1, 24'h0);
    end

    rnd_pal = 1'b0;
    repeat (4) idle();
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
